// File: rtl/adc_capture_ctrl.sv
// Capture sequencer: arms on start, optionally waits for a trigger, decimates and packs
// two-channel ADC samples into AXI-stream beats through a 2-entry buffer. Trigger option: ADC_CAPTURE_TRIG_EN.
module adc_capture_ctrl #(
  parameter int DATA_WIDTH = 14,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  aclk,
  input  logic                  reset,
  input  logic                  ctrl_start,
  input  logic                  ctrl_abort,
  input  logic [LEN_WIDTH-1:0]  ctrl_len,
  input  logic [3:0]            ctrl_decim,
`ifdef ADC_CAPTURE_TRIG_EN
  input  logic [DATA_WIDTH-1:0] trig_level,
`endif
  input  logic                  adc_valid,
  input  logic [DATA_WIDTH-1:0] adc_data_a,
  input  logic [DATA_WIDTH-1:0] adc_data_b,
  output logic [31:0]           m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  status_busy,
  output logic                  status_done,
  output logic                  status_overflow,
  output logic [LEN_WIDTH-1:0]  status_count
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_TRIG = 2'd1,
    S_CAPTURE   = 2'd2,
    S_DRAIN     = 2'd3
  } state_t;

  function automatic logic [31:0] pack_beat(input logic [DATA_WIDTH-1:0] a,
                                            input logic [DATA_WIDTH-1:0] b);
    logic signed [15:0] ea;
    logic signed [15:0] eb;
    ea = 16'(signed'(a));
    eb = 16'(signed'(b));
    return {eb, ea};
  endfunction

  state_t               state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] count_q, count_d;
  logic [3:0]           decim_q, decim_d;
  logic [3:0]           dcnt_q, dcnt_d;
  logic                 done_q, done_d;
  logic                 ovf_q, ovf_d;
  logic                 busy_q, busy_d;
  // Buffer entries are {tlast, tdata}; head_q drives the stream outputs directly.
  logic [32:0]          head_q, head_d;
  logic [32:0]          tail_q, tail_d;
  logic [1:0]           fcnt_q, fcnt_d;
`ifdef ADC_CAPTURE_TRIG_EN
  logic                  prev_ok_q, prev_ok_d;
  logic [DATA_WIDTH-1:0] prev_a_q, prev_a_d;
  logic                  cross_s;
`endif

  logic        rd_s;
  logic        wr_s;
  logic        due_s;
  logic        last_s;
  logic [32:0] beat_s;

  // Next-state, intake, buffer and status logic.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    decim_d = decim_q;
    dcnt_d  = dcnt_q;
    count_d = count_q;
    done_d  = done_q;
    ovf_d   = ovf_q;
    head_d  = head_q;
    tail_d  = tail_q;
    fcnt_d  = fcnt_q;
    due_s   = 1'b0;
    wr_s    = 1'b0;
`ifdef ADC_CAPTURE_TRIG_EN
    prev_ok_d = prev_ok_q;
    prev_a_d  = prev_a_q;
    cross_s   = prev_ok_q && ($signed(prev_a_q) < $signed(trig_level)) &&
                ($signed(adc_data_a) >= $signed(trig_level));
`endif
    rd_s   = (fcnt_q != 2'd0) && m_axis_tready;
    last_s = (count_q == (len_q - LEN_WIDTH'(1)));
    beat_s = {last_s, pack_beat(adc_data_a, adc_data_b)};

    if (rd_s && head_q[32]) begin
      done_d = 1'b1;
    end else begin
      done_d = done_q;
    end

    case (state_q)
      S_IDLE: begin
        if (ctrl_start && (ctrl_len != {LEN_WIDTH{1'b0}})) begin
          len_d   = ctrl_len;
          decim_d = ctrl_decim;
          count_d = {LEN_WIDTH{1'b0}};
          done_d  = 1'b0;
          ovf_d   = 1'b0;
          dcnt_d  = 4'd0;
`ifdef ADC_CAPTURE_TRIG_EN
          prev_ok_d = 1'b0;
          state_d   = S_WAIT_TRIG;
`else
          state_d   = S_CAPTURE;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
`ifdef ADC_CAPTURE_TRIG_EN
      S_WAIT_TRIG: begin
        if (ctrl_abort) begin
          state_d = S_DRAIN;
        end else if (adc_valid) begin
          prev_ok_d = 1'b1;
          prev_a_d  = adc_data_a;
          if (cross_s) begin
            // The crossing sample itself is beat 0 of the decimation sequence.
            due_s   = 1'b1;
            dcnt_d  = (decim_q == 4'd0) ? 4'd0 : 4'd1;
            state_d = S_CAPTURE;
          end else begin
            state_d = S_WAIT_TRIG;
          end
        end else begin
          state_d = S_WAIT_TRIG;
        end
      end
`endif
      S_CAPTURE: begin
        if (ctrl_abort) begin
          state_d = S_DRAIN;
        end else if (adc_valid) begin
          due_s  = (dcnt_q == 4'd0);
          dcnt_d = (dcnt_q == decim_q) ? 4'd0 : (dcnt_q + 4'd1);
        end else begin
          state_d = S_CAPTURE;
        end
      end
      S_DRAIN: begin
        if ((fcnt_q == 2'd0) || ((fcnt_q == 2'd1) && rd_s)) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A full buffer drops the sample even if a read happens this cycle.
    if (due_s) begin
      if (fcnt_q == 2'd2) begin
        ovf_d = 1'b1;
      end else begin
        wr_s    = 1'b1;
        count_d = count_q + LEN_WIDTH'(1);
        if (last_s) begin
          state_d = S_DRAIN;
        end else begin
          state_d = state_d;
        end
      end
    end else begin
      wr_s = 1'b0;
    end

    case ({wr_s, rd_s})
      2'b10: begin
        if (fcnt_q == 2'd0) begin
          head_d = beat_s;
        end else begin
          tail_d = beat_s;
        end
        fcnt_d = fcnt_q + 2'd1;
      end
      2'b01: begin
        if (fcnt_q == 2'd2) begin
          head_d = tail_q;
        end else begin
          head_d = head_q;
        end
        fcnt_d = fcnt_q - 2'd1;
      end
      2'b11: begin
        head_d = beat_s;
        fcnt_d = fcnt_q;
      end
      default: begin
        fcnt_d = fcnt_q;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q <= S_IDLE;
      len_q   <= {LEN_WIDTH{1'b0}};
      decim_q <= 4'd0;
      dcnt_q  <= 4'd0;
      count_q <= {LEN_WIDTH{1'b0}};
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      head_q  <= 33'd0;
      tail_q  <= 33'd0;
      fcnt_q  <= 2'd0;
`ifdef ADC_CAPTURE_TRIG_EN
      prev_ok_q <= 1'b0;
      prev_a_q  <= {DATA_WIDTH{1'b0}};
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      decim_q <= decim_d;
      dcnt_q  <= dcnt_d;
      count_q <= count_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      fcnt_q  <= fcnt_d;
`ifdef ADC_CAPTURE_TRIG_EN
      prev_ok_q <= prev_ok_d;
      prev_a_q  <= prev_a_d;
`endif
    end
  end

  assign m_axis_tdata    = head_q[31:0];
  assign m_axis_tlast    = head_q[32];
  assign m_axis_tvalid   = (fcnt_q != 2'd0);
  assign status_busy     = busy_q;
  assign status_done     = done_q;
  assign status_overflow = ovf_q;
  assign status_count    = count_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Randomized self-checking bench for adc_capture_ctrl against a queue-based reference model.
module tb_adc_capture_ctrl;
  localparam int DW = 14;
  localparam int LW = 16;
`ifdef ADC_CAPTURE_TRIG_EN
  localparam bit TRIG_EN = 1'b1;
`else
  localparam bit TRIG_EN = 1'b0;
`endif

  logic          aclk = 1'b0;
  logic          reset, ctrl_start, ctrl_abort;
  logic [LW-1:0] ctrl_len;
  logic [3:0]    ctrl_decim;
  logic [DW-1:0] trig_level;
  logic          adc_valid;
  logic [DW-1:0] adc_data_a, adc_data_b;
  logic [31:0]   m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic          status_busy, status_done, status_overflow;
  logic [LW-1:0] status_count;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  adc_capture_ctrl #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .aclk(aclk), .reset(reset), .ctrl_start(ctrl_start), .ctrl_abort(ctrl_abort),
    .ctrl_len(ctrl_len), .ctrl_decim(ctrl_decim),
`ifdef ADC_CAPTURE_TRIG_EN
    .trig_level(trig_level),
`endif
    .adc_valid(adc_valid), .adc_data_a(adc_data_a), .adc_data_b(adc_data_b),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .status_busy(status_busy), .status_done(status_done),
    .status_overflow(status_overflow), .status_count(status_count)
  );

  // Reference model: buffer contents as a queue plus frame bookkeeping.
  logic [32:0] mq[$];
  bit m_busy, m_intake, m_wait, m_done, m_ovf, m_prev_ok;
  int m_len, m_decim, m_count, m_vcount, m_prev_a;
  bit hs, hs_last;
  logic [31:0] hs_data;

  function automatic int sext14(input int x);
    int v;
    v = x & 32'h3FFF;
    return (v >= 8192) ? v - 16384 : v;
  endfunction

  function automatic logic [31:0] expect_beat(input int a, input int b);
    int va, vb;
    va = sext14(a);
    vb = sext14(b);
    return 32'(((vb & 32'hFFFF) << 16) | (va & 32'hFFFF));
  endfunction

  task automatic model_clear();
    mq.delete();
    m_busy = 0; m_intake = 0; m_wait = 0; m_done = 0; m_ovf = 0; m_prev_ok = 0;
    m_len = 0; m_decim = 0; m_count = 0; m_vcount = 0; m_prev_a = 0;
  endtask

  task automatic model_update(input bit st, input bit ab, input bit v, input int a, input int b,
                              input bit tr);
    bit rd, wr, was_drain, due;
    logic [32:0] nb, dummy;
    int sa;
    rd = (mq.size() > 0) && tr;
    wr = 0;
    nb = 33'd0;
    was_drain = m_busy && !m_intake;
    if (!m_busy) begin
      if (st && ctrl_len != 0) begin
        m_busy = 1; m_intake = 1; m_len = int'(ctrl_len); m_decim = int'(ctrl_decim);
        m_count = 0; m_done = 0; m_ovf = 0; m_vcount = 0; m_prev_ok = 0; m_wait = TRIG_EN;
      end
    end else if (m_intake) begin
      if (ab) begin
        m_intake = 0;
      end else if (v) begin
        due = 0;
        if (m_wait) begin
          sa = sext14(a);
          if (m_prev_ok && m_prev_a < sext14(int'(trig_level)) && sa >= sext14(int'(trig_level))) begin
            m_wait = 0;
            m_vcount = 0;
          end
          m_prev_ok = 1;
          m_prev_a = sa;
        end
        if (!m_wait) begin
          due = (m_vcount % (m_decim + 1)) == 0;
          m_vcount++;
        end
        if (due) begin
          if (mq.size() >= 2) begin
            m_ovf = 1;
          end else begin
            wr = 1;
            nb = {1'(m_count == m_len - 1), expect_beat(a, b)};
            m_count++;
            if (m_count == m_len) m_intake = 0;
          end
        end
      end
    end
    if (rd) begin
      if (mq[0][32]) m_done = 1;
      dummy = mq.pop_front();
    end
    if (wr) mq.push_back(nb);
    if (was_drain && mq.size() == 0) m_busy = 0;
  endtask

  // One clock cycle: drive inputs, advance the model, sample #1 after the edge.
  task automatic step(input bit st, input bit ab, input bit v, input int a, input int b, input bit tr);
    ctrl_start = st; ctrl_abort = ab; adc_valid = v;
    adc_data_a = a[DW-1:0]; adc_data_b = b[DW-1:0]; m_axis_tready = tr;
    hs = m_axis_tvalid && tr; hs_data = m_axis_tdata; hs_last = m_axis_tlast;
    model_update(st, ab, v, a, b, tr);
    @(posedge aclk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; ctrl_start = 1'b1; ctrl_len = 16'd5; adc_valid = 1'b1; m_axis_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge aclk);
      #1;
      checks++;
      if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata, status_busy, status_done, status_overflow,
           status_count} !== 52'd0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: tvalid=%b tlast=%b tdata=%h busy=%b done=%b ovf=%b count=%0d, all required 0",
                 i, m_axis_tvalid, m_axis_tlast, m_axis_tdata, status_busy, status_done,
                 status_overflow, status_count);
      end
    end
    reset = 1'b0;
    model_clear();
    step(0, 0, 0, 0, 0, 1);
    checks++;
    if (m_axis_tvalid !== 1'b0 || status_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: tvalid=%b busy=%b, required 0 0", m_axis_tvalid, status_busy);
    end
  endtask

  task automatic test_basic();
    logic [32:0] got[$];
    int a0, n;
    a0 = $urandom_range(0, 8000);
    ctrl_len = 16'd8; ctrl_decim = 4'd0;
    step(1, 0, 0, 0, 0, 1);
    n = a0;
    step(0, 0, 1, n, ~n, 1);
    n++;
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== expect_beat(a0, ~a0)) begin
      errors++;
      $display("FAIL basic_latency: tvalid=%b tdata=%h, required 1 %h", m_axis_tvalid, m_axis_tdata,
               expect_beat(a0, ~a0));
    end
    for (int i = 0; i < 100 && status_busy; i++) begin
      step(0, 0, 1, n, ~n, 1);
      n++;
      if (hs) got.push_back({hs_last, hs_data});
    end
    checks++;
    if (status_busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_timeout: busy=%b, required 0", status_busy);
    end
    checks++;
    if (got.size() != 8) begin
      errors++;
      $display("FAIL basic_beats: got %0d beats, required 8", got.size());
    end
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i] !== {1'(i == 7), expect_beat(a0 + i, ~(a0 + i))}) begin
        errors++;
        $display("FAIL basic_beat%0d: got %h, required %h", i, got[i],
                 {1'(i == 7), expect_beat(a0 + i, ~(a0 + i))});
      end
    end
    checks++;
    if (status_done !== 1'b1 || status_overflow !== 1'b0) begin
      errors++;
      $display("FAIL basic_status: done=%b ovf=%b, required 1 0", status_done, status_overflow);
    end
  endtask

  task automatic test_decim_backpressure();
    logic [32:0] got[$];
    int a0;
    bit tr, sv, sl;
    logic [31:0] sd;
    a0 = $urandom_range(0, 6000);
    ctrl_len = 16'd5; ctrl_decim = 4'd3;
    step(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 200 && (status_busy || i == 0); i++) begin
      sv = m_axis_tvalid; sd = m_axis_tdata; sl = m_axis_tlast;
      tr = (i % 2) == 1;
      step(0, 0, 1, a0 + i, a0 + i + 1000, tr);
      if (hs) got.push_back({hs_last, hs_data});
      if (sv && !tr) begin
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== sd || m_axis_tlast !== sl) begin
          errors++;
          $display("FAIL decim_stable: tvalid=%b tdata=%h tlast=%b, required 1 %h %b",
                   m_axis_tvalid, m_axis_tdata, m_axis_tlast, sd, sl);
        end
      end
    end
    checks++;
    if (got.size() != 5 || status_busy !== 1'b0) begin
      errors++;
      $display("FAIL decim_beats: got %0d beats busy=%b, required 5 0", got.size(), status_busy);
    end
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i] !== {1'(i == 4), expect_beat(a0 + 4 * i, a0 + 4 * i + 1000)}) begin
        errors++;
        $display("FAIL decim_beat%0d: got %h, required %h", i, got[i],
                 {1'(i == 4), expect_beat(a0 + 4 * i, a0 + 4 * i + 1000)});
      end
    end
    checks++;
    if (status_overflow !== 1'b0 || status_done !== 1'b1) begin
      errors++;
      $display("FAIL decim_status: ovf=%b done=%b, required 0 1", status_overflow, status_done);
    end
  endtask

  task automatic test_overflow();
    int beats, lasts, lastpos;
    beats = 0; lasts = 0; lastpos = -1;
    ctrl_len = 16'd16; ctrl_decim = 4'd0;
    step(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 300 && (status_busy || i == 0); i++) begin
      step(0, 0, 1, $urandom_range(0, 16383), $urandom_range(0, 16383), i >= 10);
      if (hs) begin
        beats++;
        if (hs_last) begin lasts++; lastpos = beats; end
      end
      checks++;
      if (m_axis_tvalid !== (mq.size() > 0) ||
          (mq.size() > 0 && {m_axis_tlast, m_axis_tdata} !== mq[0])) begin
        errors++;
        $display("FAIL ovf_stream cycle %0d: tvalid=%b beat=%h, required %b %h", i, m_axis_tvalid,
                 {m_axis_tlast, m_axis_tdata}, mq.size() > 0, (mq.size() > 0) ? mq[0] : 33'd0);
      end
    end
    checks++;
    if (beats != 16 || lasts != 1 || lastpos != 16) begin
      errors++;
      $display("FAIL ovf_frame: beats=%0d lasts=%0d lastpos=%0d, required 16 1 16", beats, lasts, lastpos);
    end
    checks++;
    if (status_overflow !== 1'b1 || status_count !== 16'd16 || status_done !== 1'b1 || status_busy !== 1'b0) begin
      errors++;
      $display("FAIL ovf_status: ovf=%b count=%0d done=%b busy=%b, required 1 16 1 0",
               status_overflow, status_count, status_done, status_busy);
    end
  endtask

  task automatic test_abort();
    int beats, lasts;
    beats = 0; lasts = 0;
    ctrl_len = 16'd100; ctrl_decim = 4'd0;
    step(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 500 && m_count < 20; i++) begin
      step(0, 0, $urandom_range(0, 3) != 0, $urandom_range(0, 16383), $urandom_range(0, 16383),
           $urandom_range(0, 3) != 0);
      if (hs) begin beats++; if (hs_last) lasts++; end
    end
    step(0, 1, 1, 1234, 4321, $urandom_range(0, 1) == 1);
    if (hs) begin beats++; if (hs_last) lasts++; end
    for (int i = 0; i < 50 && status_busy; i++) begin
      step(0, 0, 1, 55, 66, $urandom_range(0, 1) == 1);
      if (hs) begin beats++; if (hs_last) lasts++; end
      checks++;
      if (m_axis_tvalid !== (mq.size() > 0) ||
          (mq.size() > 0 && {m_axis_tlast, m_axis_tdata} !== mq[0])) begin
        errors++;
        $display("FAIL abort_drain: tvalid=%b beat=%h, required %b %h", m_axis_tvalid,
                 {m_axis_tlast, m_axis_tdata}, mq.size() > 0, (mq.size() > 0) ? mq[0] : 33'd0);
      end
    end
    checks++;
    if (beats != 20 || lasts != 0) begin
      errors++;
      $display("FAIL abort_beats: beats=%0d lasts=%0d, required 20 0", beats, lasts);
    end
    checks++;
    if (status_busy !== 1'b0 || status_done !== 1'b0 || status_count !== 16'd20) begin
      errors++;
      $display("FAIL abort_status: busy=%b done=%b count=%0d, required 0 0 20", status_busy,
               status_done, status_count);
    end
    beats = 0; lasts = 0;
    ctrl_len = 16'd3;
    step(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 50 && status_busy; i++) begin
      step(0, 0, 1, 300 + i, 400 + i, 1);
      if (hs) begin
        checks++;
        if ({hs_last, hs_data} !== {1'(beats == 2), expect_beat(300 + beats, 400 + beats)}) begin
          errors++;
          $display("FAIL abort_refill_beat%0d: got %h, required %h", beats, {hs_last, hs_data},
                   {1'(beats == 2), expect_beat(300 + beats, 400 + beats)});
        end
        beats++;
      end
    end
    checks++;
    if (beats != 3 || status_done !== 1'b1 || status_overflow !== 1'b0 || status_busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_refill: beats=%0d done=%b ovf=%b busy=%b, required 3 1 0 0", beats,
               status_done, status_overflow, status_busy);
    end
  endtask

  task automatic test_random();
    trig_level = 14'd0;
    for (int f = 0; f < 6; f++) begin
      ctrl_len = 16'd0;
      step(1, 0, 0, 0, 0, 1);
      checks++;
      if (status_busy !== 1'b0) begin
        errors++;
        $display("FAIL rand_zero_len frame %0d: busy=%b, required 0", f, status_busy);
      end
      ctrl_len = (f == 0) ? 16'd1 : 16'($urandom_range(2, 12));
      ctrl_decim = 4'($urandom_range(0, 3));
      step(1, 0, 0, 0, 0, 1);
      for (int i = 0; i < 1000 && (m_busy || status_busy); i++) begin
        ctrl_len = 16'($urandom_range(0, 20));
        ctrl_decim = 4'($urandom_range(0, 15));
        step(m_busy && ($urandom_range(0, 15) == 0), $urandom_range(0, 99) == 0,
             $urandom_range(0, 3) != 0, $urandom_range(0, 16383), $urandom_range(0, 16383),
             $urandom_range(0, 3) != 0);
        checks++;
        if (m_axis_tvalid !== (mq.size() > 0) ||
            (mq.size() > 0 && {m_axis_tlast, m_axis_tdata} !== mq[0])) begin
          errors++;
          $display("FAIL rand_stream frame %0d cycle %0d: tvalid=%b beat=%h, required %b %h", f, i,
                   m_axis_tvalid, {m_axis_tlast, m_axis_tdata}, mq.size() > 0,
                   (mq.size() > 0) ? mq[0] : 33'd0);
        end
        checks++;
        if ({status_busy, status_done, status_overflow} !== {m_busy, m_done, m_ovf} ||
            status_count !== m_count[LW-1:0]) begin
          errors++;
          $display("FAIL rand_status frame %0d cycle %0d: busy/done/ovf=%b%b%b count=%0d, required %b%b%b %0d",
                   f, i, status_busy, status_done, status_overflow, status_count, m_busy, m_done,
                   m_ovf, m_count);
        end
      end
      checks++;
      if (status_busy !== 1'b0) begin
        errors++;
        $display("FAIL rand_timeout frame %0d: busy=%b, required 0", f, status_busy);
      end
    end
  endtask

`ifdef ADC_CAPTURE_TRIG_EN
  task automatic test_trigger();
    logic [32:0] got[$];
    int stray;
    trig_level = 14'd100;
    ctrl_len = 16'd4; ctrl_decim = 4'd0;
    step(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 100 && status_busy; i++) begin
      step(0, 0, 1, 90 + i, 590 + i, 1);
      if (hs) got.push_back({hs_last, hs_data});
    end
    checks++;
    if (got.size() != 4 || status_busy !== 1'b0) begin
      errors++;
      $display("FAIL trig_beats: got %0d beats busy=%b, required 4 0", got.size(), status_busy);
    end
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i] !== {1'(i == 3), expect_beat(100 + i, 600 + i)}) begin
        errors++;
        $display("FAIL trig_beat%0d: got %h, required %h", i, got[i],
                 {1'(i == 3), expect_beat(100 + i, 600 + i)});
      end
    end
    stray = 0;
    step(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 40; i++) begin
      step(0, 0, 1, 150, 7, 1);
      if (m_axis_tvalid !== 1'b0 || status_busy !== 1'b1) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL trig_held: %0d cycles with tvalid=1 or busy=0, required 0", stray);
    end
    step(0, 1, 1, 150, 7, 1);
    for (int i = 0; i < 10 && status_busy; i++) step(0, 0, 1, 150, 7, 1);
    checks++;
    if (status_busy !== 1'b0 || status_done !== 1'b0) begin
      errors++;
      $display("FAIL trig_abort: busy=%b done=%b, required 0 0", status_busy, status_done);
    end
  endtask
`endif

  initial begin
    reset = 1'b1; ctrl_start = 1'b0; ctrl_abort = 1'b0; ctrl_len = 16'd0; ctrl_decim = 4'd0;
    trig_level = 14'd0; adc_valid = 1'b0; adc_data_a = 14'd0; adc_data_b = 14'd0;
    m_axis_tready = 1'b0;
    model_clear();
    test_reset();
    test_basic();
    test_decim_backpressure();
    test_overflow();
    test_abort();
`ifdef ADC_CAPTURE_TRIG_EN
    test_trigger();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/adc_capture_ctrl.md
# adc_capture_ctrl

Capture sequencer between the AD9643 LVDS deserializer and the AXI-stream output. It arms on a start command from the AXI-lite register bank and optionally waits for a trigger. It then decimates and packs a fixed number of two-channel samples into AXI-stream beats, ending the frame with `tlast`. A 2-entry buffer absorbs `tready` stalls. The ADC side cannot stall, so any sample that finds the buffer full is dropped and flagged.

## Interface
- `DATA_WIDTH`, 14: ADC sample width per channel, two's complement.
- `LEN_WIDTH`, 16: width of the capture length and sample counter.
- `aclk`  in  1: single clock for all logic; same clock as the ADC sample stream (`m_axis_aclk` domain).
- `reset`  in  1: synchronous, active-high reset.
- `ctrl_start`  in  1: one-cycle pulse; arms a capture.
- `ctrl_abort`  in  1: one-cycle pulse; stops the capture.
- `ctrl_len`  in  LEN_WIDTH: number of beats per capture; latched at start.
- `ctrl_decim`  in  4: keep 1 of every `ctrl_decim+1` valid samples; latched at start.
- `trig_level`  in  DATA_WIDTH: signed trigger threshold on channel A. Only present with the macro defined.
- `adc_valid`  in  1: a new sample pair is present this cycle.
- `adc_data_a`, `adc_data_b`  in  DATA_WIDTH each: channel A and channel B samples.
- `m_axis_tdata`  out  32: `{sext16(b), sext16(a)}`.
- `m_axis_tvalid`  out  1: AXI-stream valid.
- `m_axis_tready`  in  1: AXI-stream ready.
- `m_axis_tlast`  out  1: marks the final beat of the capture.
- `status_busy`  out  1: high in any state other than IDLE.
- `status_done`  out  1: sticky; set when the last beat handshakes; cleared by an accepted start.
- `status_overflow`  out  1: sticky; set on a dropped sample; cleared by an accepted start.
- `status_count`  out  LEN_WIDTH: number of samples written into the buffer in the current capture.

## Operation
- States:
  - IDLE
  - WAIT_TRIG (macro only)
  - CAPTURE
  - DRAIN
- IDLE:
  - `ctrl_start` is accepted only if `ctrl_len != 0`.
  - An accepted start latches `ctrl_len` and `ctrl_decim`, clears done, overflow and count, then moves to WAIT_TRIG (or to CAPTURE when the macro is off).
  - A start with `ctrl_len == 0` is ignored.
  - `ctrl_start` is ignored in every state other than IDLE.
- CAPTURE:
  - The decimation counter is cleared on entry.
  - On every `adc_valid` the counter advances modulo `ctrl_decim+1`.
  - A sample is due when `adc_valid` is high and the counter is 0.
  - A due sample with the buffer not full is written, count increments, and the tlast bit is stored when `count == len-1`.
  - A due sample with the buffer full is dropped: overflow is set and count is unchanged, so the frame always carries exactly `len` beats.
  - After the write with `count == len-1`, go to DRAIN.
- DRAIN: no new writes. When the buffer is empty (the tlast beat has handshaked), go to IDLE with done set.
- Buffer:
  - 2-entry FIFO; `tdata`/`tlast` come straight from the head entry.
  - A simultaneous write and read while full is not allowed: full means a due sample is dropped even if `tready` is high that cycle.
  - A simultaneous write and read while holding 1 entry is allowed.
- Abort:
  - Takes effect in WAIT_TRIG or CAPTURE: intake stops and the state moves to DRAIN.
  - Buffered beats drain normally, with `tlast` only if one was already stored.
  - After the drain, go to IDLE with done not set.
  - `ctrl_abort` in IDLE or DRAIN is ignored.
  - If abort and a due sample arrive in the same cycle, abort wins and the sample is not written.
- `reset` at any point returns the block to IDLE, empties the buffer and clears all status.

## Timing
- Reset values: `m_axis_tvalid=0`, `m_axis_tlast=0`, `m_axis_tdata=0`, `status_*=0`.
- Latency: a due sample at cycle N appears on `m_axis_tdata` with `tvalid=1` at cycle N+1, provided the buffer was empty.
- Once `tvalid` is high, it and `tdata`/`tlast` stay stable until `tready`, except under `reset`.
- `status_busy` rises the cycle after an accepted start and falls the cycle after the tlast handshake (or after the abort drain completes).
- `status_done` rises in the same cycle `status_busy` falls.

## Configuration
- `ADC_CAPTURE_TRIG_EN` defined:
  - The `trig_level` port and the WAIT_TRIG state exist.
  - WAIT_TRIG leaves on the first valid sample where the previous valid A is below `trig_level` and the current A is at or above it (signed compare).
  - That crossing sample is the first captured beat, with the decimation counter at 0.
  - The "previous" register is invalid right after start, so the first valid sample after start cannot trigger.
- `ADC_CAPTURE_TRIG_EN` undefined: the `trig_level` port and WAIT_TRIG are absent. Start goes directly to CAPTURE and the first valid sample is beat 0.

## Test plan
- Reset: hold `reset` high for 4 cycles while driving `adc_valid` and `ctrl_start` -> all outputs 0, no beats.
- Basic frame: `len=8`, `decim=0`, `tready=1`, counter data `a=n`, `b=~n` -> 8 beats, consecutive `a` values, `tlast` only on beat 7, done=1, overflow=0.
- Decimation and backpressure: `len=5`, `decim=3`, `tready` toggling 1/0 -> beats carry `a = a0, a0+4, …, a0+16`; `tdata` stable while `tready=0`; overflow=0.
- Overflow: `len=16`, `decim=0`, `tready=0` for 10 cycles then 1 -> overflow=1, still exactly 16 beats with `tlast` on the 16th; `status_count` ends at 16.
- Abort: `len=100`, abort after 20 beats written -> remaining buffered beats drain, no `tlast`, done=0, busy=0. A following start with `len=3` produces a clean 3-beat frame.
- Trigger (macro on): `trig_level=100`, ramp A 90→110 -> first beat has `a=100`; a ramp held at 150 never triggers; busy stays 1 until abort.
